// File: rtl/hazard_defs.sv
// rtl/hazard_defs.sv - shared constants and helpers for the forwarding/hazard unit
package hazard_defs;

    // Select value meaning "read the operand from the register file"
    localparam int FWD_SEL_RF = 0;

    // Packed tracking entry layout: {rd, valid, wr, load}, load at bit 0
    localparam int ENT_LOAD_BIT  = 0;
    localparam int ENT_WR_BIT    = 1;
    localparam int ENT_VALID_BIT = 2;
    localparam int ENT_RD_LSB    = 3;

    function automatic int ent_w(input int reg_aw);
        return reg_aw + ENT_RD_LSB;
    endfunction

    // Select must encode 0 (regfile) plus stages 1..depth
    function automatic int sel_w(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// rtl/fwd_match_prio.sv - youngest-match priority encoder for one source operand
module fwd_match_prio
    import hazard_defs::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    localparam int EW       = ent_w(REG_AW),
    localparam int SELW     = sel_w(FWD_DEPTH)
) (
    input  logic [REG_AW-1:0]       rs_i,
    input  logic                    used_i,
    input  logic [FWD_DEPTH*EW-1:0] ents_i,
    output logic                    hit_o,
    output logic [SELW-1:0]         idx_o,
    output logic                    load_o
);

    // Scan oldest to youngest so the smallest index overwrites older hits;
    // an X compare makes the if-condition false, yielding no match.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        load_o = 1'b0;
        for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
            if (used_i && (rs_i != '0)
                && ents_i[j*EW + ENT_VALID_BIT]
                && ents_i[j*EW + ENT_WR_BIT]
                && (ents_i[j*EW + ENT_RD_LSB +: REG_AW] == rs_i)) begin
                hit_o  = 1'b1;
                idx_o  = SELW'(j);
                load_o = ents_i[j*EW + ENT_LOAD_BIT];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use stall generation
module fwd_hazard_unit
    import hazard_defs::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16,
    localparam int SELW     = sel_w(FWD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int EW = ent_w(REG_AW);
    localparam logic [SELW-1:0] LOAD_LAT_W = SELW'(LOAD_LAT);

    // ent_q[0] is EX, ent_q[k] is post-EX stage k
    logic [EW-1:0]           ent_q [FWD_DEPTH+1];
    logic [EW-1:0]           ent_d;
    logic [FWD_DEPTH*EW-1:0] match_ents;
    logic [NUM_SRC*SELW-1:0] sel_d, sel_q;
    logic [NUM_SRC-1:0]      src_hit, src_load, src_early;
    logic [SELW-1:0]         src_idx [NUM_SRC];
    logic [CNT_W-1:0]        cnt_q;
    logic                    stall;

    // Only entries that will sit in stages 1..FWD_DEPTH next cycle can forward
    always_comb begin
        match_ents = '0;
        for (int j = 0; j < FWD_DEPTH; j++) begin
            match_ents[j*EW +: EW] = ent_q[j];
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match_prio #(
            .REG_AW    (REG_AW),
            .FWD_DEPTH (FWD_DEPTH)
        ) u_match (
            .rs_i   (id_rs[s*REG_AW +: REG_AW]),
            .used_i (id_rs_used[s]),
            .ents_i (match_ents),
            .hit_o  (src_hit[s]),
            .idx_o  (src_idx[s]),
            .load_o (src_load[s])
        );
    end

    // Per-source select and "load not yet forwardable" detection
    always_comb begin
        sel_d     = '0;
        src_early = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            sel_d[s*SELW +: SELW] = src_hit[s] ? (src_idx[s] + SELW'(1))
                                               : SELW'(FWD_SEL_RF);
            src_early[s] = src_hit[s] & src_load[s] & (src_idx[s] < LOAD_LAT_W);
        end
        stall = id_valid & ~flush & (|src_early);
        ent_d = {id_rd, 1'b1, id_reg_write & (id_rd != '0), id_is_load};
    end

    // Advance the tracking pipe; flush kills the EX slot even while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FWD_DEPTH; k++) ent_q[k] <= '0;
            sel_q <= '0;
        end else if (!hold) begin
            for (int k = 1; k <= FWD_DEPTH; k++) ent_q[k] <= ent_q[k-1];
            if (flush || stall || !id_valid) begin
                ent_q[0] <= '0;
                sel_q    <= '0;
            end else begin
                ent_q[0] <= ent_d;
                sel_q    <= sel_d;
            end
        end else if (flush) begin
            ent_q[0] <= '0;
            sel_q    <= '0;
        end
    end

    // Saturating count of cycles actually lost to load-use stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && !hold && !flush && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign id_stall    = stall;
    assign ex_valid    = ent_q[0][ENT_VALID_BIT];
    assign ex_fwd_sel  = sel_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_is_load;
    logic        id_stall;
    logic        ex_valid;
    logic [3:0]  ex_fwd_sel;
    logic [15:0] stall_count;

    int total  = 0;
    int passed = 0;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_stall     (id_stall),
        .ex_valid     (ex_valid),
        .ex_fwd_sel   (ex_fwd_sel),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [1:0] used, input logic [4:0] rd,
                          input logic wr, input logic ld);
        id_valid     = v;
        id_rs        = {r1, r0};
        id_rs_used   = used;
        id_rd        = rd;
        id_reg_write = wr;
        id_is_load   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_sel",   32'(ex_fwd_sel), 32'h0);
        chk("rst_cnt",   32'(stall_count), 32'd0);
        chk("rst_stall", 32'(id_stall), 32'd0);
        rst_n = 1'b1;

        // add x5 ; add x6,x5,x1
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0); #1;
        chk("b2b_stall", 32'(id_stall), 32'd0);
        tick();
        chk("b2b_sel",   32'(ex_fwd_sel), 32'h1);
        chk("b2b_valid", 32'(ex_valid), 32'd1);
        idle(2);

        // add x5 ; nop ; sub x7,x2,x5
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        idle(1);
        set_id(1'b1, 5'd2, 5'd5, 2'b11, 5'd7, 1'b1, 1'b0); #1;
        chk("gap_stall", 32'(id_stall), 32'd0);
        tick();
        chk("gap_sel", 32'(ex_fwd_sel), 32'h8);
        idle(2);

        // add x5 ; add x5 ; use x5 -> youngest wins
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd5, 5'd3, 2'b11, 5'd10, 1'b1, 1'b0); tick();
        chk("young_sel", 32'(ex_fwd_sel), 32'h1);
        idle(2);

        // lw x7 ; add x8,x7,x7 -> one bubble, then forward from stage 2
        set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0); #1;
        chk("lu_stall1", 32'(id_stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_bsel",   32'(ex_fwd_sel), 32'h0);
        chk("lu_cnt",    32'(stall_count), 32'd1);
        chk("lu_stall2", 32'(id_stall), 32'd0);
        tick();
        chk("lu_valid",  32'(ex_valid), 32'd1);
        chk("lu_sel",    32'(ex_fwd_sel), 32'hA);
        chk("lu_cnt2",   32'(stall_count), 32'd1);
        idle(2);

        // lw x0 ; read x0 -> nothing to forward, no stall
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd11, 1'b1, 1'b0); #1;
        chk("x0_stall", 32'(id_stall), 32'd0);
        tick();
        chk("x0_sel",   32'(ex_fwd_sel), 32'h0);
        chk("x0_valid", 32'(ex_valid), 32'd1);
        // lw x9 ; sources name x9 but are not read
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd9, 5'd9, 2'b00, 5'd12, 1'b1, 1'b0); #1;
        chk("unused_stall", 32'(id_stall), 32'd0);
        tick();
        chk("unused_sel", 32'(ex_fwd_sel), 32'h0);
        chk("unused_cnt", 32'(stall_count), 32'd1);
        idle(2);

        // add x3 ; lw x7,0(x3) ; add x8,x7 under hold, then flush during hold
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); tick();
        chk("hd_lwsel", 32'(ex_fwd_sel), 32'h1);
        set_id(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);
        hold = 1'b1; #1;
        chk("hd_stall0", 32'(id_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hd_valid", 32'(ex_valid), 32'd1);
            chk("hd_sel",   32'(ex_fwd_sel), 32'h1);
            chk("hd_cnt",   32'(stall_count), 32'd1);
            chk("hd_stall", 32'(id_stall), 32'd1);
        end
        flush = 1'b1; #1;
        chk("fl_stall", 32'(id_stall), 32'd0);
        tick();
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_sel",   32'(ex_fwd_sel), 32'h0);
        chk("fl_cnt",   32'(stall_count), 32'd1);
        hold = 1'b0; flush = 1'b0; #1;
        chk("post_fl_stall", 32'(id_stall), 32'd0);
        tick();
        chk("post_fl_valid", 32'(ex_valid), 32'd1);
        chk("post_fl_sel",   32'(ex_fwd_sel), 32'h0);
        idle(2);

        // lw x7 in EX, dependent add in ID, async reset mid-stall
        set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0); #1;
        chk("ar_stall_pre", 32'(id_stall), 32'd1);
        #2;
        rst_n = 1'b0; #1;
        chk("ar_valid", 32'(ex_valid), 32'd0);
        chk("ar_sel",   32'(ex_fwd_sel), 32'h0);
        chk("ar_cnt",   32'(stall_count), 32'd0);
        chk("ar_stall", 32'(id_stall), 32'd0);
        tick();
        rst_n = 1'b1; #1;
        chk("ar_rel_stall", 32'(id_stall), 32'd0);
        tick();
        chk("ar_rel_valid", 32'(ex_valid), 32'd1);
        chk("ar_rel_sel",   32'(ex_fwd_sel), 32'h0);
        chk("ar_rel_cnt",   32'(stall_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
